reg_file_mp: RTL and testbench

- Parametrised successor to the core's 2-read/1-write register file.
- Adds a configurable number of read ports and a sequenced post-reset initialisation: x2/x3 get programmable init values, all other registers are cleared.
- Adds a halted-mode debug access port with a req/ack handshake for the serial debugger.
- Sits in the RISC-V datapath between decode (read addresses) and writeback (write port); the debug port is driven by the serial debug controller.

---
 rtl/reg_file_mp.sv | 167 ++++++++++++++++
 tb/tb_reg_file_mp.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-read-port register file for the RISC-V core.
// After reset an init sweep writes every register (x2/x3 get programmable
// values, the rest are cleared) while o_busy is high. A halted-mode debug port
// with a req/ack handshake gives the serial debugger read/write access.
// Optional feature macro: RF_BYPASS_EN -- write-through forwarding from the
// core write port to the read ports in the same cycle.
module reg_file_mp #(
  parameter int                DWIDTH  = 32,
  parameter int                AWIDTH  = 5,
  parameter int                MDEPTH  = 32,
  parameter int                NRD     = 2,
  parameter logic [DWIDTH-1:0] SP_INIT = DWIDTH'(32'h0000_0F00),
  parameter logic [DWIDTH-1:0] GP_INIT = DWIDTH'(32'h0000_0100)
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  i_dbg_run,
  input  logic                  WE,
  input  logic [AWIDTH-1:0]     WA,
  input  logic [DWIDTH-1:0]     WD,
  input  logic [NRD*AWIDTH-1:0] RA,
  output logic [NRD*DWIDTH-1:0] RD,
  input  logic                  i_dbg_req,
  input  logic                  i_dbg_we,
  input  logic [AWIDTH-1:0]     i_dbg_addr,
  input  logic [DWIDTH-1:0]     i_dbg_wdata,
  output logic                  o_dbg_ack,
  output logic [DWIDTH-1:0]     o_dbg_rdata,
  output logic                  o_busy
);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  // Index width that covers exactly the implemented registers.
  localparam int                IW       = (MDEPTH > 1) ? $clog2(MDEPTH) : 1;
  localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(MDEPTH - 1);

  logic [DWIDTH-1:0] rf_q [MDEPTH];
  logic [1:0]        state_q, state_d;
  logic [AWIDTH-1:0] idx_q, idx_d;
  logic [DWIDTH-1:0] dbg_rdata_q, dbg_rdata_d;

  logic              busy;
  logic              core_we;
  logic              dbg_acc;
  logic              dbg_wr;
  logic              wr_en;
  logic [IW-1:0]     wr_idx;
  logic [DWIDTH-1:0] wr_data;

  // Value the init sweep places in register a.
  function automatic logic [DWIDTH-1:0] init_val(input logic [AWIDTH-1:0] a);
    if (a == AWIDTH'(2)) return SP_INIT;
    if (a == AWIDTH'(3)) return GP_INIT;
    return '0;
  endfunction

  // True for a writable/readable address: not x0 and inside the array.
  function automatic logic addr_ok(input logic [AWIDTH-1:0] a);
    return (a != '0) && (32'(a) < MDEPTH);
  endfunction

  assign busy    = (state_q == ST_INIT);
  // Core writes need run=1, debug accepts need run=0, so they never collide.
  assign core_we = WE && addr_ok(WA) && i_dbg_run && !busy;
  assign dbg_acc = (state_q == ST_IDLE) && i_dbg_req && !i_dbg_run;
  assign dbg_wr  = dbg_acc && i_dbg_we && addr_ok(i_dbg_addr);

  assign o_busy      = busy;
  assign o_dbg_ack   = (state_q == ST_ACK);
  assign o_dbg_rdata = dbg_rdata_q;

  // Next-state logic for the init sweep / debug handshake FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    idx_d       = idx_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      ST_INIT: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + AWIDTH'(1);
        end
      end
      ST_IDLE: begin
        if (dbg_acc) begin
          state_d = ST_ACK;
          if (!i_dbg_we) begin
            dbg_rdata_d = addr_ok(i_dbg_addr) ? rf_q[i_dbg_addr[IW-1:0]] : '0;
          end
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: begin
        state_d = ST_INIT;
        idx_d   = '0;
      end
    endcase
  end

  // Control and debug read-data state; reset restarts the sweep and drops any ack.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_INIT;
      idx_q       <= '0;
      dbg_rdata_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      idx_q       <= idx_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Single array write port shared by the init sweep, debug writes and core writes.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    if (busy) begin
      wr_en   = 1'b1;
      wr_idx  = idx_q[IW-1:0];
      wr_data = init_val(idx_q);
    end else if (dbg_wr) begin
      wr_en   = 1'b1;
      wr_idx  = i_dbg_addr[IW-1:0];
      wr_data = i_dbg_wdata;
    end else if (core_we) begin
      wr_en   = 1'b1;
      wr_idx  = WA[IW-1:0];
      wr_data = WD;
    end
  end

  // Register array storage.
  // NOTE: the array has no reset; the post-reset init sweep gives it defined contents.
  always_ff @(posedge CLK) begin
    if (wr_en) rf_q[wr_idx] <= wr_data;
  end

  // Asynchronous read ports: init values during the sweep, array contents afterwards.
  always_comb begin : rd_ports
    logic [AWIDTH-1:0] ra;
    ra = '0;
    RD = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = RA[k*AWIDTH +: AWIDTH];
      if (busy) begin
        RD[k*DWIDTH +: DWIDTH] = init_val(ra);
      end else if (addr_ok(ra)) begin
        RD[k*DWIDTH +: DWIDTH] = rf_q[ra[IW-1:0]];
      end
`ifdef RF_BYPASS_EN
      // Forward the qualified core write to any port reading the same register.
      if (core_we && (ra == WA)) begin
        RD[k*DWIDTH +: DWIDTH] = WD;
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed self-checking bench for reg_file_mp with default
// parameters (32 x 32-bit, two read ports). Expected values are hand-computed.
module tb_reg_file_mp;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        i_dbg_run;
  logic        WE;
  logic [4:0]  WA;
  logic [31:0] WD;
  logic [9:0]  RA;
  logic [63:0] RD;
  logic        i_dbg_req;
  logic        i_dbg_we;
  logic [4:0]  i_dbg_addr;
  logic [31:0] i_dbg_wdata;
  logic        o_dbg_ack;
  logic [31:0] o_dbg_rdata;
  logic        o_busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt;
  int acks;

`ifdef RF_BYPASS_EN
  localparam logic [31:0] EXP_SAME_CYC_7 = 32'hDEAD_BEEF;
  localparam logic [31:0] EXP_SAME_CYC_4 = 32'hA5A5_A5A5;
`else
  localparam logic [31:0] EXP_SAME_CYC_7 = 32'h0000_0000;
  localparam logic [31:0] EXP_SAME_CYC_4 = 32'h0000_0000;
`endif

  reg_file_mp dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .i_dbg_run   (i_dbg_run),
    .WE          (WE),
    .WA          (WA),
    .WD          (WD),
    .RA          (RA),
    .RD          (RD),
    .i_dbg_req   (i_dbg_req),
    .i_dbg_we    (i_dbg_we),
    .i_dbg_addr  (i_dbg_addr),
    .i_dbg_wdata (i_dbg_wdata),
    .o_dbg_ack   (o_dbg_ack),
    .o_dbg_rdata (o_dbg_rdata),
    .o_busy      (o_busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Count cycles until o_busy falls (bounded), tallying acks seen meanwhile.
  task automatic wait_sweep();
    cnt  = 0;
    acks = 0;
    while (o_busy && cnt < 100) begin
      tick();
      cnt++;
      if (o_dbg_ack) acks++;
    end
  endtask

  initial begin
    RSTn        = 1'b1;
    i_dbg_run   = 1'b1;
    WE          = 1'b0;
    WA          = '0;
    WD          = '0;
    RA          = '0;
    i_dbg_req   = 1'b0;
    i_dbg_we    = 1'b0;
    i_dbg_addr  = '0;
    i_dbg_wdata = '0;
    #1 RSTn = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_busy",  32'(o_busy), 32'd1);
    check("rst_ack",   32'(o_dbg_ack), 32'd0);
    check("rst_rdata", o_dbg_rdata, 32'h0);

    // Release reset; during the sweep reads return init values
    RSTn = 1'b1;
    RA   = {5'd3, 5'd2};
    #1;
    check("init_rd0_x2", RD[31:0],  32'h0000_0F00);
    check("init_rd1_x3", RD[63:32], 32'h0000_0100);
    wait_sweep();
    check("sweep_len", 32'(cnt), 32'd32);

    // Post-sweep contents
    check("x2_sp", RD[31:0],  32'h0000_0F00);
    check("x3_gp", RD[63:32], 32'h0000_0100);
    RA = {5'd1, 5'd5};
    #1;
    check("x5_clr", RD[31:0],  32'h0);
    check("x1_clr", RD[63:32], 32'h0);
    RA = {5'd0, 5'd31};
    #1;
    check("x31_clr", RD[31:0],  32'h0);
    check("x0_rd",   RD[63:32], 32'h0);

    // Core write to x7; same-cycle read sees old value (or forwarded value)
    WE = 1'b1; WA = 5'd7; WD = 32'hDEAD_BEEF; RA = {5'd0, 5'd7};
    #1;
    check("wr7_same_cycle", RD[31:0], EXP_SAME_CYC_7);
    tick();
    WE = 1'b0;
    #1;
    check("wr7_next_cycle", RD[31:0], 32'hDEAD_BEEF);

    // Write to x0 is discarded
    WE = 1'b1; WA = 5'd0; WD = 32'h0000_1234; RA = {5'd0, 5'd0};
    tick();
    WE = 1'b0;
    #1;
    check("x0_write_ignored", RD[31:0], 32'h0);

    // Both ports reading the register being written
    WE = 1'b1; WA = 5'd4; WD = 32'hA5A5_A5A5; RA = {5'd4, 5'd4};
    #1;
    check("byp_rd0", RD[31:0],  EXP_SAME_CYC_4);
    check("byp_rd1", RD[63:32], EXP_SAME_CYC_4);
    tick();
    WE = 1'b0;
    #1;
    check("x4_rd0_after", RD[31:0],  32'hA5A5_A5A5);
    check("x4_rd1_after", RD[63:32], 32'hA5A5_A5A5);

    // Debug write x9 while halted
    i_dbg_run = 1'b0;
    i_dbg_req = 1'b1; i_dbg_we = 1'b1; i_dbg_addr = 5'd9; i_dbg_wdata = 32'hCAFE_F00D;
    #1;
    check("dbgw_no_ack_yet", 32'(o_dbg_ack), 32'd0);
    tick();
    check("dbgw_ack", 32'(o_dbg_ack), 32'd1);
    i_dbg_req = 1'b0;
    tick();
    check("dbgw_ack_pulse", 32'(o_dbg_ack), 32'd0);
    RA = {5'd0, 5'd9};
    #1;
    check("dbgw_x9", RD[31:0], 32'hCAFE_F00D);

    // Debug read x9; req held through ACK is not re-accepted there
    i_dbg_req = 1'b1; i_dbg_we = 1'b0; i_dbg_addr = 5'd9;
    tick();
    check("dbgr_ack",   32'(o_dbg_ack), 32'd1);
    check("dbgr_rdata", o_dbg_rdata, 32'hCAFE_F00D);
    tick();
    check("dbgr_ack_drop", 32'(o_dbg_ack), 32'd0);
    i_dbg_req = 1'b0;
    tick();
    check("dbgr_no_reaccept", 32'(o_dbg_ack), 32'd0);
    check("dbgr_rdata_held",  o_dbg_rdata, 32'hCAFE_F00D);

    // Debug read of x3 and x0
    i_dbg_req = 1'b1; i_dbg_addr = 5'd3;
    tick();
    check("dbgr_x3", o_dbg_rdata, 32'h0000_0100);
    i_dbg_req = 1'b0;
    tick();
    i_dbg_req = 1'b1; i_dbg_addr = 5'd0;
    tick();
    check("dbgr_x0", o_dbg_rdata, 32'h0);
    i_dbg_req = 1'b0;
    tick();

    // Core write while halted is ignored
    WE = 1'b1; WA = 5'd9; WD = 32'h0;
    tick();
    WE = 1'b0;
    #1;
    check("halted_core_wr", RD[31:0], 32'hCAFE_F00D);

    // Debug write to x0 is acked but discarded
    i_dbg_req = 1'b1; i_dbg_we = 1'b1; i_dbg_addr = 5'd0; i_dbg_wdata = 32'hFFFF_FFFF;
    tick();
    check("dbgw_x0_ack", 32'(o_dbg_ack), 32'd1);
    i_dbg_req = 1'b0;
    tick();
    RA = {5'd0, 5'd0};
    #1;
    check("dbgw_x0_ignored", RD[31:0], 32'h0);

    // Request while running stays pending
    i_dbg_run = 1'b1;
    i_dbg_req = 1'b1; i_dbg_we = 1'b0; i_dbg_addr = 5'd7;
    acks = 0;
    repeat (10) begin
      tick();
      if (o_dbg_ack) acks++;
    end
    check("run_pending_no_ack", 32'(acks), 32'd0);
    i_dbg_run = 1'b0;
    #1;
    check("run_drop_no_ack", 32'(o_dbg_ack), 32'd0);
    tick();
    check("run_drop_ack",   32'(o_dbg_ack), 32'd1);
    check("run_drop_rdata", o_dbg_rdata, 32'hDEAD_BEEF);
    i_dbg_req = 1'b0;
    tick();
    check("run_drop_ack_end", 32'(o_dbg_ack), 32'd0);

    // Reset during ACK drops the ack and clears read data
    i_dbg_req = 1'b1; i_dbg_addr = 5'd2;
    tick();
    check("pre_rst_ack", 32'(o_dbg_ack), 32'd1);
    RSTn = 1'b0;
    i_dbg_req = 1'b0;
    #1;
    check("rst_in_ack_ack",   32'(o_dbg_ack), 32'd0);
    check("rst_in_ack_busy",  32'(o_busy), 32'd1);
    check("rst_in_ack_rdata", o_dbg_rdata, 32'h0);
    tick();
    RSTn = 1'b1;
    wait_sweep();
    check("sweep2_len", 32'(cnt), 32'd32);

    // Put 0x55 into x20, then interrupt a sweep at idx 10
    i_dbg_run = 1'b1;
    WE = 1'b1; WA = 5'd20; WD = 32'h55;
    tick();
    WE = 1'b0;
    RA = {5'd0, 5'd20};
    #1;
    check("x20_written", RD[31:0], 32'h55);
    RSTn = 1'b0;
    tick();
    RSTn = 1'b1;
    // Core writes during the sweep are ignored
    WE = 1'b1; WA = 5'd20; WD = 32'h77;
    repeat (10) tick();
    check("mid_sweep_busy", 32'(o_busy), 32'd1);
    WE = 1'b0;
    RSTn = 1'b0;
    #1;
    check("mid_sweep_rst_busy", 32'(o_busy), 32'd1);
    tick();
    RSTn = 1'b1;
    // Debug requests during the sweep are ignored
    i_dbg_run = 1'b0;
    i_dbg_req = 1'b1; i_dbg_we = 1'b1; i_dbg_addr = 5'd20; i_dbg_wdata = 32'h99;
    wait_sweep();
    i_dbg_req = 1'b0;
    check("sweep3_len",      32'(cnt), 32'd32);
    check("sweep3_no_ack",   32'(acks), 32'd0);
    RA = {5'd2, 5'd20};
    #1;
    check("x20_cleared", RD[31:0],  32'h0);
    check("x2_restored", RD[63:32], 32'h0000_0F00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
